cmd_uart_wrapper: RTL

CMD_UART_WRAPPER -- requirements
Module: cmd_uart_wrapper

---
 rtl/cmd_uart_wrapper.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cmd_uart_wrapper.sv
// Two-byte UART command receiver plus single-byte response transmitter (8N1, LSB first).
// cmd_rdy one cycle after the second stop-bit sample; tx_done after 10 bit periods; trmt ignored while busy.
module cmd_uart_wrapper #(
   parameter int BAUD_CYCLES = 2604
) (
   input  logic        clk,
   input  logic        RST_n,
   input  logic        RX,
   output logic        TX,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        trmt,
   output logic        tx_done
);

   localparam int CW = $clog2(BAUD_CYCLES + 1);
   localparam logic [CW-1:0] HALF    = CW'(BAUD_CYCLES / 2);
   localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_CYCLES - 1);

   typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
   typedef enum logic {W_HIGH, W_LOW} wr_state_t;
   typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

   rx_state_t       rx_state_q;
   logic            rx_meta_q, rx_sync_q, rx_prev_q;
   logic [CW-1:0]   rx_cnt_q;
   logic [3:0]      rx_bit_q;
   logic [7:0]      rx_shift_q;
   logic            rx_rdy_q;
   logic            start_det;

   wr_state_t       wr_state_q;
   logic [15:0]     cmd_q;
   logic            cmd_rdy_q;

   tx_state_t       tx_state_q;
   logic [9:0]      tx_shift_q;
   logic [CW-1:0]   tx_cnt_q;
   logic [3:0]      tx_bit_q;
   logic            tx_done_q;

   assign start_det = (rx_state_q == RX_IDLE) && rx_prev_q && !rx_sync_q;

   // Receiver: bit 0 is the start bit, 1..8 data, 9 stop.
   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_rdy_q   <= 1'b0;
      end else begin
         rx_meta_q <= RX;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
         rx_rdy_q  <= 1'b0;
         case (rx_state_q)
            RX_IDLE: begin
               if (start_det) begin
                  rx_cnt_q   <= HALF;
                  rx_bit_q   <= '0;
                  rx_state_q <= RX_RECV;
               end
            end
            default: begin
               if (rx_cnt_q != '0) begin
                  rx_cnt_q <= rx_cnt_q - CW'(1);
               end else begin
                  rx_cnt_q <= FULL_M1;
                  rx_bit_q <= rx_bit_q + 4'd1;
                  if (rx_bit_q == 4'd0) begin
                     if (rx_sync_q) rx_state_q <= RX_IDLE;
                  end else if (rx_bit_q == 4'd9) begin
                     rx_state_q <= RX_IDLE;
                     if (rx_sync_q) rx_rdy_q <= 1'b1;
                  end else begin
                     rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                  end
               end
            end
         endcase
      end
   end

   // Byte assembler; a completing second byte beats a simultaneous clear.
   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
         wr_state_q <= W_HIGH;
         cmd_q      <= '0;
         cmd_rdy_q  <= 1'b0;
      end else begin
         if (rx_rdy_q) begin
            if (wr_state_q == W_HIGH) begin
               cmd_q[15:8] <= rx_shift_q;
               wr_state_q  <= W_LOW;
            end else begin
               cmd_q[7:0]  <= rx_shift_q;
               wr_state_q  <= W_HIGH;
            end
         end
         if (rx_rdy_q && wr_state_q == W_LOW)
            cmd_rdy_q <= 1'b1;
         else if (clr_cmd_rdy || (start_det && wr_state_q == W_HIGH))
            cmd_rdy_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
         tx_state_q <= TX_IDLE;
         tx_shift_q <= '1;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_done_q  <= 1'b0;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               if (trmt) begin
                  tx_shift_q <= {1'b1, resp, 1'b0};
                  tx_done_q  <= 1'b0;
                  tx_cnt_q   <= '0;
                  tx_bit_q   <= '0;
                  tx_state_q <= TX_XMIT;
               end
            end
            default: begin
               if (tx_cnt_q == FULL_M1) begin
                  tx_cnt_q   <= '0;
                  tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                  if (tx_bit_q == 4'd9) begin
                     tx_bit_q   <= '0;
                     tx_done_q  <= 1'b1;
                     tx_state_q <= TX_IDLE;
                  end else begin
                     tx_bit_q <= tx_bit_q + 4'd1;
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + CW'(1);
               end
            end
         endcase
      end
   end

   assign TX      = tx_shift_q[0];
   assign cmd     = cmd_q;
   assign cmd_rdy = cmd_rdy_q;
   assign tx_done = tx_done_q;

endmodule
